// File: rtl/iomem_fabric_pkg.sv
// iomem_fabric_pkg: shared FSM state type and default constants for iomem_fabric.
package iomem_fabric_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [63:0] DEFAULT_SLOT_BASE   = 64'h0A09_0807_0605_0403;
    localparam logic [7:0]  DEFAULT_STATUS_BASE = 8'h0F;
    localparam logic [31:0] TIMEOUT_RDATA       = 32'hFFFF_FFFF;
endpackage

// File: rtl/iomem_decode.sv
// iomem_decode: combinational map of addr[31:24] to slot hit/index and status-register select.
module iomem_decode
    import iomem_fabric_pkg::*;
#(
    parameter int                     NUM_SLOTS   = 8,
    parameter logic [NUM_SLOTS*8-1:0] SLOT_BASE   = (NUM_SLOTS*8)'(DEFAULT_SLOT_BASE),
    parameter logic [7:0]             STATUS_BASE = DEFAULT_STATUS_BASE
)(
    input  logic [7:0] i_addr_hi,
    output logic       o_hit,
    output logic [3:0] o_slot_idx,
    output logic       o_is_status
);
    always_comb begin
        o_hit      = 1'b0;
        o_slot_idx = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (i_addr_hi == SLOT_BASE[8*i +: 8]) begin
                o_hit      = 1'b1;
                o_slot_idx = 4'(i);
            end
        end
        o_is_status = i_addr_hi == STATUS_BASE;
    end
endmodule

// File: rtl/iomem_fabric.sv
// iomem_fabric: routes one master onto NUM_SLOTS peripheral slots plus a status register.
// Define IOMEM_FABRIC_TIMEOUT_EN to add the access timeout counter and error logging.
module iomem_fabric
    import iomem_fabric_pkg::*;
#(
    parameter int                     NUM_SLOTS      = 8,
    parameter logic [NUM_SLOTS*8-1:0] SLOT_BASE      = (NUM_SLOTS*8)'(DEFAULT_SLOT_BASE),
    parameter logic [7:0]             STATUS_BASE    = DEFAULT_STATUS_BASE,
    parameter int                     TIMEOUT_CYCLES = 1023
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic [3:0]              m_wstrb,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic [NUM_SLOTS-1:0]    s_valid,
    input  logic [NUM_SLOTS-1:0]    s_ready,
    input  logic [NUM_SLOTS*32-1:0] s_rdata,
    output logic [3:0]              s_wstrb,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic                    err_irq
);
    state_t                r_state, w_state_nxt;
    logic                  w_hit, w_is_status, w_start, w_sel_ready, w_timeout;
    logic [3:0]            w_idx, r_slot, r_wstrb;
    logic [NUM_SLOTS-1:0]  w_onehot, r_s_valid, w_s_valid_nxt;
    logic                  r_m_ready, w_m_ready_nxt;
    logic [31:0]           r_m_rdata, w_m_rdata_nxt, w_sel_rdata, w_status, r_addr, r_wdata;
    logic [7:0]            w_err_count;
    logic [3:0]            w_err_slot;
    logic [15:0]           w_err_addr;

    iomem_decode #(.NUM_SLOTS(NUM_SLOTS), .SLOT_BASE(SLOT_BASE), .STATUS_BASE(STATUS_BASE)) u_decode (
        .i_addr_hi  (m_addr[31:24]),
        .o_hit      (w_hit),
        .o_slot_idx (w_idx),
        .o_is_status(w_is_status)
    );

    assign w_start     = r_state == IDLE && m_valid;
    assign w_sel_ready = |(s_ready & r_s_valid);
    assign w_status    = {w_err_count, w_err_slot, 4'b0, w_err_addr};

    // Read data follows the latched slot index; ready only qualifies completion.
    always_comb begin
        w_onehot    = '0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_onehot[i] = w_idx == 4'(i);
            if (r_slot == 4'(i)) w_sel_rdata = s_rdata[32*i +: 32];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_m_ready_nxt = 1'b0;
        w_m_rdata_nxt = r_m_rdata;
        w_s_valid_nxt = r_s_valid;
        case (r_state)
            IDLE: if (m_valid) begin
                if (w_hit) begin
                    w_state_nxt   = ACCESS;
                    w_s_valid_nxt = w_onehot;
                end else begin
                    w_state_nxt   = RESP;
                    w_m_ready_nxt = 1'b1;
                    w_m_rdata_nxt = (w_is_status && m_wstrb == 4'b0) ? w_status : '0;
                end
            end
            ACCESS: if (!m_valid) begin
                w_state_nxt   = IDLE;
                w_s_valid_nxt = '0;
            end else if (w_sel_ready || w_timeout) begin
                w_state_nxt   = RESP;
                w_m_ready_nxt = 1'b1;
                w_m_rdata_nxt = w_sel_ready ? w_sel_rdata : TIMEOUT_RDATA;
                w_s_valid_nxt = '0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_m_ready <= 1'b0;
            r_m_rdata <= '0;
            r_s_valid <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_m_ready <= w_m_ready_nxt;
            r_m_rdata <= w_m_rdata_nxt;
            r_s_valid <= w_s_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot  <= '0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_slot  <= w_idx;
            r_wstrb <= m_wstrb;
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
        end
    end

`ifdef IOMEM_FABRIC_TIMEOUT_EN
    logic [15:0] r_cnt, w_cnt_inc, r_err_addr;
    logic [7:0]  r_err_count;
    logic [3:0]  r_err_slot;
    logic        r_err_irq;

    assign w_cnt_inc = r_cnt + 16'd1;
    // A ready on the final cycle completes normally and records no error.
    assign w_timeout = r_state == ACCESS && m_valid && !w_sel_ready && w_cnt_inc == 16'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_err_irq   <= 1'b0;
            r_err_count <= '0;
            r_err_slot  <= '0;
            r_err_addr  <= '0;
        end else begin
            r_cnt     <= r_state == ACCESS ? w_cnt_inc : '0;
            r_err_irq <= w_timeout;
            if (w_timeout) begin
                r_err_count <= r_err_count == 8'hFF ? r_err_count : r_err_count + 8'd1;
                r_err_slot  <= r_slot;
                r_err_addr  <= r_addr[31:16];
            end else if (w_start && !w_hit && w_is_status && |m_wstrb) begin
                r_err_count <= '0;
            end
        end
    end

    assign err_irq     = r_err_irq;
    assign w_err_count = r_err_count;
    assign w_err_slot  = r_err_slot;
    assign w_err_addr  = r_err_addr;
`else
    assign w_timeout   = 1'b0;
    assign err_irq     = 1'b0;
    assign w_err_count = '0;
    assign w_err_slot  = '0;
    assign w_err_addr  = '0;
`endif

    assign m_ready = r_m_ready;
    assign m_rdata = r_m_rdata;
    assign s_valid = r_s_valid;
    assign s_wstrb = r_wstrb;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
endmodule
